// File: rtl/status_led_ctrl.sv
// Fixed-priority blink-code sequencer for the single active-low status LED.
// Up to four requesters share the LED; an activity stretch shows while no code plays.
module status_led_ctrl #(
  parameter int unsigned TICK_CYCLES = 2500000,
  parameter int unsigned ON_TICKS    = 2,
  parameter int unsigned OFF_TICKS   = 2,
  parameter int unsigned GAP_TICKS   = 10,
  parameter int unsigned ACT_CYCLES  = 1250000
) (
  input  logic        osc25m,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] req_code,
  input  logic        act,
  output logic        led,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic        seq_done
);

  localparam int unsigned CW = $clog2(TICK_CYCLES) + 1;
  localparam int unsigned SW = $clog2(ACT_CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [7:0]    ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0]    OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [SW-1:0] ACT_LOAD = SW'(ACT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [2:0]    pulse_q, pulse_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic [1:0]    id_q, id_d;
  logic          done_q, done_d;

  logic          tick;
  logic          grant;
  logic [1:0]    win_id;
  logic [2:0]    win_code;

  // Lowest index with a non-zero code wins.
  always_comb begin
    grant    = 1'b0;
    win_id   = '0;
    win_code = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!grant && req[i] && (req_code[3*i +: 3] != 3'd0)) begin
        grant    = 1'b1;
        win_id   = i[1:0];
        win_code = req_code[3*i +: 3];
      end
    end
  end

  assign tick = (cyc_q == CYC_LAST);

  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    id_d      = id_q;
    done_d    = 1'b0;
    stretch_d = act ? ACT_LOAD
                    : ((stretch_q != '0) ? stretch_q - SW'(1) : '0);

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ON;
          id_d    = win_id;
          pulse_d = win_code;
        end
      end
      S_ON: begin
        if (tick && (tcnt_q == ON_LAST)) begin
          pulse_d = pulse_q - 3'd1;
          state_d = (pulse_q == 3'd1) ? S_GAP : S_OFF;
        end
      end
      S_OFF: begin
        if (tick && (tcnt_q == OFF_LAST)) state_d = S_ON;
      end
      S_GAP: begin
        if (tick && (tcnt_q == GAP_LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Both counters restart on every phase change so each phase is exact.
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      cyc_d  = '0;
      tcnt_d = '0;
    end else begin
      cyc_d  = tick ? '0 : cyc_q + CW'(1);
      tcnt_d = tick ? tcnt_q + 8'd1 : tcnt_q;
    end

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:  led_d = (stretch_d == '0);
      S_ON:    led_d = 1'b0;
      default: led_d = 1'b1;
    endcase
  end

  always_ff @(posedge osc25m or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      tcnt_q    <= '0;
      pulse_q   <= '0;
      stretch_q <= '0;
      led_q     <= 1'b1;
      busy_q    <= 1'b0;
      id_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      tcnt_q    <= tcnt_d;
      pulse_q   <= pulse_d;
      stretch_q <= stretch_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      id_q      <= id_d;
      done_q    <= done_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign cur_id   = id_q;
  assign seq_done = done_q;

endmodule

// File: doc/status_led_ctrl.md
# status_led_ctrl

Sequencer and arbiter for the board's single active-low status LED, driven from the 25 MHz PHY clock. Four status requesters each request a blink code: N short pulses followed by a long gap. The block grants the LED to one requester at a time by fixed priority and plays that code to completion. When no code is playing, a stretched activity pulse may light the LED. It replaces direct LED drive in the top level so that firmware, link, and error logic can share the one LED.

## Interface
- TICK_CYCLES, 2500000, osc25m cycles per blink tick (100 ms); ≥1
- ON_TICKS, 2, ticks the LED is lit per pulse; ≥1
- OFF_TICKS, 2, ticks dark between pulses of one code; ≥1
- GAP_TICKS, 10, ticks dark after the last pulse; ≥1
- ACT_CYCLES, 1250000, activity stretch length in cycles (50 ms); ≥1

- osc25m  in  1  sole clock, 25 MHz from PHY
- rst  in  1  reset, asynchronous, active-high
- req  in  4  level request per requester; bit 0 is highest priority
- req_code  in  12  packed 3-bit pulse counts; requester i uses bits [3i+2:3i]; value 0 = requester ignored
- act  in  1  activity strobe, sampled every cycle
- led  out  1  LED drive, active low (0 = lit), registered
- busy  out  1  high while a code sequence is playing (ON/OFF/GAP)
- cur_id  out  2  requester currently granted; holds its last value in IDLE
- seq_done  out  1  one-cycle pulse when a sequence finishes

## Operation
- States: IDLE, ON, OFF, GAP.
- A requester i is valid when req[i]=1 and its code is non-zero.
- IDLE: if any requester is valid, the lowest valid index wins.
  - Latch the winner's id into cur_id and its code into the pulse counter (3 bits).
  - Clear the tick counter and go to ON.
  - Otherwise stay in IDLE.
- ON: led=0. After ON_TICKS ticks, decrement the pulse counter. Go to GAP if this was the last pulse (counter was 1), else go to OFF. Clear the tick counter on the transition.
- OFF: led=1. After OFF_TICKS ticks, go to ON.
- GAP: led=1. After GAP_TICKS ticks, go to IDLE and assert seq_done for one cycle.
- Grants are non-preemptive. Once a sequence starts, changes to req and req_code are ignored until it returns to IDLE. Arbitration takes place only in IDLE, including the first IDLE cycle, when seq_done is high.
- Tick generator: a cycle counter of width $clog2(TICK_CYCLES)+1 that counts 0..TICK_CYCLES-1 and wraps.
  - A tick occurs on the wrap.
  - The counter is held at 0 in IDLE and cleared on every state change.
  - Each phase therefore lasts exactly (phase_TICKS × TICK_CYCLES) cycles.
  - Phase tick counters are sized for 8-bit tick parameters.
- Activity stretch:
  - act=1 loads the stretch counter with ACT_CYCLES. Otherwise the counter decrements to 0 and saturates there.
  - The counter runs in every state. A new act pulse restarts it.
  - In IDLE, led = ~(stretch≠0).
  - In ON/OFF/GAP the stretch counter has no effect on led.
- Reset (asynchronous, any state):
  - state=IDLE; led=1; busy=0; cur_id=0; seq_done=0.
  - All counters are cleared. The stretch counter is cleared to 0, so the LED is dark after reset.

## Timing
- Arbitration → LED lit: 1 cycle. A valid req sampled at edge k gives state=ON and led=0 after edge k+1 (led is registered from the next state).
- busy = 1 exactly while the state is ON, OFF, or GAP. busy and cur_id update on the same edge as led.
- For a code of N pulses, the sequence length is N·ON_TICKS·TICK_CYCLES + (N−1)·OFF_TICKS·TICK_CYCLES + GAP_TICKS·TICK_CYCLES cycles. seq_done is high during the first IDLE cycle after that.
- Back-to-back: a request still valid when seq_done is high starts its next ON one cycle after seq_done.
- act → led=0 in IDLE: 1 cycle. led stays low for exactly ACT_CYCLES cycles after the last act.
- If act and a valid request arrive on the same IDLE cycle, the request wins; the next cycle shows ON.

## Test plan
Bench parameters: TICK_CYCLES=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, ACT_CYCLES=5.
1. Reset → led=1, busy=0, cur_id=0, seq_done=0. Release with no inputs → outputs unchanged for 100 cycles.
2. req=4'b0100, code2=3 → three led=0 windows of 8 cycles each, separated by two 4-cycle dark gaps, then 12 cycles dark. busy high for 44 cycles, cur_id=2, seq_done pulse on cycle 45.
3. req=4'b1010 with code1=2, code3=1, held → cur_id=1 plays 2 pulses (32 cycles). seq_done, then next cycle cur_id=3 plays 1 pulse (20 cycles).
4. req=4'b0001 with code0=0, req[2] with code2=1 → cur_id=2 wins; requester 0 is never granted.
5. act pulse in IDLE → led=0 for 5 cycles, starting 1 cycle later. A second act at cycle 3 extends it to 8 cycles total. An act during ON/OFF/GAP has no visible effect after the sequence ends, provided the stretch counter has expired by then.
6. Assert rst asynchronously mid-ON of a 3-pulse code → led=1 and busy=0 immediately, with no clock edge needed. After release, a held request restarts from pulse 1.
